// File: rtl/stream_arb_mux_pkg.sv
// Shared types and helpers for the stream arbiter/mux.
package mux_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // A select field is never narrower than one bit, even for a single channel.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_arb_mux_rr_pick.sv
// Combinational picker: first requester searching from base upward with wrap,
// or from index 0 when rotation is disabled (fixed priority).
module rr_pick #(
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] base,
   input  logic             rotate_en,
   output logic [SEL_W-1:0] grant_idx,
   output logic             grant_any
);

   int idx;

   // Walk the search order backwards so the earliest position in the order wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = rotate_en ? ((int'(base) + k) % N) : k;
         if (req[idx]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/stream_arb_mux.sv
// N valid/ready channels merged onto one registered output stream, with
// fixed or rotating priority and a forced-select override.
module stream_arb_mux
   import mux_pkg::*;
#(
   parameter int        WIDTH    = 8,
   parameter int        N        = 4,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   localparam int       SEL_W    = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data [0:N-1],
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic             force_en,
   input  logic [SEL_W-1:0] force_sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] out_sel
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] arb_idx;
   logic             arb_any;
   logic [SEL_W-1:0] win_idx;
   logic             win_any;
   logic             force_hit;
   logic             load_en;
   logic [WIDTH-1:0] win_data;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_pick (
      .req       (in_valid),
      .base      (ptr),
      .rotate_en (ARB_MODE == ARB_RR),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   // Winner selection, one-hot ready and data steering; an out-of-range
   // force_sel matches no channel and therefore never grants.
   always_comb begin
      load_en   = !out_valid || out_ready;
      force_hit = 1'b0;
      for (int i = 0; i < N; i++)
         if (force_sel == SEL_W'(i) && in_valid[i]) force_hit = 1'b1;
      win_idx  = force_en ? force_sel : arb_idx;
      win_any  = !rst && load_en && (force_en ? force_hit : arb_any);
      win_data = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (win_idx == SEL_W'(i)) begin
            win_data    = in_data[i];
            in_ready[i] = win_any;
         end
      end
   end

   // Output register and rotating pointer; the pointer only advances on
   // arbitrated (non-forced) grants in round-robin mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (win_any) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win_idx;
            if (!force_en && ARB_MODE == ARB_RR) begin
               if (win_idx == SEL_W'(N - 1)) ptr <= '0;
               else                          ptr <= win_idx + 1'b1;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
